mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-master, one-slave arbiter for the native valid/ready memory bus. It shares a single slave port, such as the AXI bridge or BRAM, between the CPU instruction port (master 0) and data port (master 1). A request that loses arbitration or arrives while the slave is busy is buffered, never dropped. Grants are round-robin, with one outstanding slave transaction at a time and a watchdog that terminates a hung slave access.

## Interface
- TIMEOUT, 1024: slave response watchdog in cycles; 0 disables it.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low.
- m0_valid, m1_valid  in  1  one-cycle request pulse per master.
- m0_instr, m1_instr  in  1  instruction-fetch attribute, forwarded unchanged.
- m0_addr, m1_addr  in  32  byte address, forwarded unchanged.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte strobes; 0 means read.
- m0_rdata, m1_rdata  out  32  response data, valid only while the matching ready is 1, otherwise 0.
- m0_ready, m1_ready  out  1  one-cycle completion pulse.
- s_valid  out  1  one-cycle request pulse to the slave.
- s_instr  out  1  slave request attribute.
- s_addr  out  32  slave request address.
- s_wdata  out  32  slave write data.
- s_wstrb  out  4  slave byte strobes.
- s_rdata  in  32  slave response data.
- s_ready  in  1  slave completion pulse.
- timeout_err  out  1  one-cycle pulse when the watchdog fires.
- overflow_err  out  1  sticky flag; set when a request is lost, cleared only by reset.

## Operation
- Each master has one pending buffer holding valid, instr, addr, wdata and wstrb. A master must not issue a new request before its previous ready.
- Two states, IDLE and BUSY. The owner register records the granted master (0 or 1). The last register records the most recently granted master and resets to 1, so master 0 wins the first tie.
- IDLE, candidates:
  - The buffered requests take precedence over live requests.
  - If no buffer is valid, the live m*_valid inputs are the candidates.
- IDLE, winner selection:
  - If there is exactly one candidate, it wins.
  - If there are two candidates, the master that is not the last register wins.
  - The winner is driven onto s_* in the same cycle, with s_valid=1.
  - Next state is BUSY, owner is set to the winner, and last is set to the winner.
  - A live request that does not win is captured into its master's buffer.
- BUSY:
  - s_valid=0 and s_* are driven to 0.
  - Any live m*_valid is captured into that master's buffer.
  - When s_ready=1, the owner's ready=1 and its rdata=s_rdata in the same cycle, combinationally. Next state is IDLE.
  - The owner's buffer is cleared when its request is issued, not at completion.
- Overflow: a live request for a master whose buffer is already valid is dropped and sets overflow_err. If that master's buffer is being issued in the same cycle, the request is captured instead of dropped.
- Watchdog:
  - A timer clears on entry to BUSY and increments every BUSY cycle without s_ready.
  - When the timer reaches TIMEOUT-1 and s_ready=0, the owner's ready=1 with rdata=0, timeout_err=1, and next state is IDLE.
  - An s_ready arriving in IDLE is ignored.
- s_ready=1 while in IDLE never produces an m*_ready.

## Timing
- Reset values: state=IDLE, both buffers invalid, last=1, timer=0, overflow_err=0. All combinational outputs are 0 until the first request.
- Reset in the middle of a transaction discards any in-flight response and both buffers.
- Uncontended request in IDLE: s_valid in the same cycle as m*_valid, giving zero added latency.
- Completion: the owner's ready is in the same cycle as s_ready.
- Buffered request: issued in the first IDLE cycle, which is the cycle after the previous completion. The minimum gap between slave requests is one cycle.
- Simultaneous requests in IDLE: the winner issues at cycle t. After it completes at cycle c, the loser issues at cycle c+1.
- A request arriving in the same cycle as s_ready is captured into its buffer and issues at the next cycle.
- Watchdog with TIMEOUT=N: timeout_err and the owner's ready occur N cycles after s_valid. With TIMEOUT=0 the arbiter waits indefinitely.
- All buffer, state, last and timer updates take effect at the next clock edge.

## Test plan
- After reset, m0 reads 0x100 in IDLE; the slave responds 3 cycles later with 0xDEADBEEF -> s_valid and s_addr=0x100 in the same cycle, then m0_ready=1 with m0_rdata=0xDEADBEEF in the response cycle, m1_ready=0.
- m0 and m1 both request at cycle 0; the slave has 2-cycle latency -> m0 issues at cycle 0 and completes at cycle 2. m1 issues from its buffer at cycle 3 and completes at cycle 5.
- Both masters re-request every time they complete, over 20 transactions -> grants strictly alternate 0,1,0,1 and no overflow_err.
- TIMEOUT=8, the slave never responds to an m1 write -> at 8 cycles after s_valid: m1_ready=1, m1_rdata=0, timeout_err pulses once. A later s_ready is ignored and the next request issues normally.
- m1 sends a second request while its first is still buffered -> overflow_err=1 and stays 1, and only the first request reaches the slave.
- Assert rst=0 while BUSY with m0 buffered, then release -> all outputs are 0. An s_ready arriving after release produces no m*_ready, and the next m0 request is granted immediately.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one native-bus slave between the CPU instruction
// port (master 0) and data port (master 1). Round-robin grants, one
// outstanding slave access, one pending buffer per master, and a
// watchdog that ends a slave access that never completes.
//
// Handshake: a request is a one-cycle valid pulse carrying instr, addr,
// wdata and wstrb (wstrb == 0 means read). The receiver answers with a
// one-cycle ready pulse, and rdata is meaningful only in that cycle (it
// is 0 otherwise). A master must not pulse valid again before it has
// seen ready for its previous request. The arbiter forwards a granted
// request to the slave in the same cycle. It returns the slave's ready
// and rdata to the owning master in the same cycle.
module mem_arbiter #(
   parameter int TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        m0_valid,
   input  logic        m0_instr,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_ready,
   input  logic        m1_valid,
   input  logic        m1_instr,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_ready,
   output logic        s_valid,
   output logic        s_instr,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   input  logic        s_ready,
   output logic        timeout_err,
   output logic        overflow_err,
   output logic        state_dbg
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   typedef struct packed {
      logic        instr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } req_t;

   // The watchdog fires when the timer holds TIMEOUT-1 with no s_ready.
   // A TIMEOUT of 0 turns the watchdog off entirely.
   localparam bit          WDOG_EN    = (TIMEOUT > 0);
   localparam logic [31:0] TIMER_LAST = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [31:0] timer_q, timer_d;

   // Pending buffers, bit/index 0 = master 0, 1 = master 1
   logic [1:0]  buf_v_q, buf_v_d;
   req_t [1:0]  buf_q;

   req_t [1:0]  live_req;
   logic [1:0]  live_v;
   logic [1:0]  cand;
   logic [1:0]  win_oh;
   logic [1:0]  issue_buf;
   logic [1:0]  live_win;
   logic [1:0]  capture;
   logic [1:0]  drop;
   logic        any_buf;
   logic        grant;
   logic        win;
   req_t        win_req;
   logic        wdog_fire;
   logic        done;

   assign live_v      = {m1_valid, m0_valid};
   assign live_req[0] = {m0_instr, m0_addr, m0_wdata, m0_wstrb};
   assign live_req[1] = {m1_instr, m1_addr, m1_wdata, m1_wstrb};
   assign state_dbg   = state_q;

   // Arbitration: pick the winner in IDLE, then work out which live
   // requests go into a buffer and which are lost.
   always_comb begin
      any_buf = |buf_v_q;
      // Buffered requests are older, so they shut out live ones entirely
      cand    = any_buf ? buf_v_q : live_v;
      grant   = (state_q == IDLE) && (cand != 2'b00);
      // On a tie the master that did not win last time goes first
      win     = (cand == 2'b11) ? ~last_q : cand[1];
      win_oh  = 2'b00;
      if (grant) begin
         win_oh = win ? 2'b10 : 2'b01;
      end
      issue_buf = any_buf ? win_oh : 2'b00;
      live_win  = any_buf ? 2'b00 : win_oh;
      win_req   = any_buf ? buf_q[win] : live_req[win];
      // A buffer that is issued this cycle frees up in time for a new
      // live request from the same master. Otherwise the live request is lost.
      capture   = live_v & ~live_win & (~buf_v_q | issue_buf);
      drop      = live_v & ~live_win & buf_v_q & ~issue_buf;
      buf_v_d   = capture | (buf_v_q & ~issue_buf);
   end

   // Completion: a slave response, or the watchdog giving up on the slave
   always_comb begin
      wdog_fire = WDOG_EN && (state_q == BUSY) && !s_ready && (timer_q == TIMER_LAST);
      done      = (state_q == BUSY) && (s_ready || wdog_fire);
   end

   // Next-state logic for the IDLE/BUSY controller, owner, last and timer
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      timer_d = 32'd0;
      case (state_q)
         IDLE: begin
            if (grant) begin
               state_d = BUSY;
               owner_d = win;
               last_d  = win;
            end
         end
         BUSY: begin
            if (done) begin
               state_d = IDLE;
            end else begin
               timer_d = timer_q + 32'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Slave-side and master-side outputs; everything idles at 0
   always_comb begin
      s_valid     = 1'b0;
      s_instr     = 1'b0;
      s_addr      = 32'd0;
      s_wdata     = 32'd0;
      s_wstrb     = 4'd0;
      m0_ready    = 1'b0;
      m1_ready    = 1'b0;
      m0_rdata    = 32'd0;
      m1_rdata    = 32'd0;
      timeout_err = wdog_fire;
      if (grant) begin
         s_valid = 1'b1;
         s_instr = win_req.instr;
         s_addr  = win_req.addr;
         s_wdata = win_req.wdata;
         s_wstrb = win_req.wstrb;
      end
      if (done) begin
         m0_ready = ~owner_q;
         m1_ready = owner_q;
      end
      // A watchdog completion returns 0 data
      if ((state_q == BUSY) && s_ready) begin
         if (owner_q) begin
            m1_rdata = s_rdata;
         end else begin
            m0_rdata = s_rdata;
         end
      end
   end

   // Controller state, round-robin pointer and watchdog timer
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         timer_q <= 32'd0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         timer_q <= timer_d;
      end
   end

   // Pending buffers: capture live requests that were not forwarded
   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_v_q <= 2'b00;
         buf_q   <= '0;
      end else begin
         buf_v_q <= buf_v_d;
         if (capture[0]) begin
            buf_q[0] <= live_req[0];
         end
         if (capture[1]) begin
            buf_q[1] <= live_req[1];
         end
      end
   end

   // Sticky overflow flag, set whenever a live request is lost
   always_ff @(posedge clk) begin
      if (!rst) begin
         overflow_err <= 1'b0;
      end else if (drop != 2'b00) begin
         overflow_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter (TIMEOUT = 8). A table of per-cycle
// vectors covers the single, contended, buffered, overflow, reset and
// watchdog cases. Hand-written sequences then cover 20 alternating
// grants against a random-latency slave, and a reset that lands in
// the middle of an access.
module tb_mem_arbiter;

   localparam logic [31:0] WD0 = 32'hA0A0_A0A0;
   localparam logic [31:0] WD1 = 32'hB1B1_B1B1;

   logic        clk;
   logic        rst;
   logic        m0_valid, m0_instr, m0_ready;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic [3:0]  m0_wstrb;
   logic        m1_valid, m1_instr, m1_ready;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m1_wstrb;
   logic        s_valid, s_instr, s_ready;
   logic [31:0] s_addr, s_wdata, s_rdata;
   logic [3:0]  s_wstrb;
   logic        timeout_err, overflow_err, state_dbg;

   mem_arbiter #(.TIMEOUT(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .m0_valid     (m0_valid),
      .m0_instr     (m0_instr),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_wstrb     (m0_wstrb),
      .m0_rdata     (m0_rdata),
      .m0_ready     (m0_ready),
      .m1_valid     (m1_valid),
      .m1_instr     (m1_instr),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_wstrb     (m1_wstrb),
      .m1_rdata     (m1_rdata),
      .m1_ready     (m1_ready),
      .s_valid      (s_valid),
      .s_instr      (s_instr),
      .s_addr       (s_addr),
      .s_wdata      (s_wdata),
      .s_wstrb      (s_wstrb),
      .s_rdata      (s_rdata),
      .s_ready      (s_ready),
      .timeout_err  (timeout_err),
      .overflow_err (overflow_err),
      .state_dbg    (state_dbg)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // ---------------- check bookkeeping ----------------
   int n_total = 0;
   int n_pass  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end else begin
         n_pass++;
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        rst;
      logic        v0;
      logic        v1;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [3:0]  ws1;
      logic        srdy;
      logic [31:0] srd;
      logic        sv;
      logic [31:0] saddr;
      logic [3:0]  sws;
      logic        sinstr;
      logic        r0;
      logic [31:0] d0;
      logic        r1;
      logic [31:0] d1;
      logic        to;
      logic        of;
   } vec_t;

   vec_t vecs [64];
   int   nv     = 0;
   logic cur_of = 1'b0;

   // New cycle record: inputs given, all outputs expected idle
   task automatic vin(input logic r, input logic v0, input logic v1,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [3:0] ws1, input logic srdy, input logic [31:0] srd);
      vec_t t;
      t        = '{default: '0};
      t.rst    = r;
      t.v0     = v0;
      t.v1     = v1;
      t.a0     = a0;
      t.a1     = a1;
      t.ws1    = ws1;
      t.srdy   = srdy;
      t.srd    = srd;
      t.of     = cur_of;
      vecs[nv] = t;
      nv++;
   endtask

   // Expect a slave request in the latest record
   task automatic es(input logic [31:0] addr, input logic [3:0] ws, input logic instr);
      vecs[nv-1].sv     = 1'b1;
      vecs[nv-1].saddr  = addr;
      vecs[nv-1].sws    = ws;
      vecs[nv-1].sinstr = instr;
   endtask

   // Expect a completion to master m in the latest record
   task automatic er(input int m, input logic [31:0] d, input logic to);
      if (m == 0) begin
         vecs[nv-1].r0 = 1'b1;
         vecs[nv-1].d0 = d;
      end else begin
         vecs[nv-1].r1 = 1'b1;
         vecs[nv-1].d1 = d;
      end
      vecs[nv-1].to = to;
   endtask

   task automatic idle_vec();
      vin(1, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic clear_inputs();
      m0_valid = 1'b0;
      m0_addr  = 32'd0;
      m1_valid = 1'b0;
      m1_addr  = 32'd0;
      m1_wstrb = 4'd0;
      s_ready  = 1'b0;
      s_rdata  = 32'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard for the alternation run ----------------
   logic [31:0] exp_q [$];
   logic [0:0]  own_q [$];

   // ---------------- main test ----------------
   initial begin
      logic        want0, want1, exp_grant, slv_pending, obs_m, exp_m;
      logic [31:0] exp_d;
      int          req_cnt, dones, slv_k, slv_lat;

      rst      = 1'b0;
      m0_instr = 1'b1;
      m1_instr = 1'b0;
      m0_wdata = WD0;
      m1_wdata = WD1;
      m0_wstrb = 4'd0;
      clear_inputs();

      // ---- build the table ----
      cur_of = 1'b0;
      vin(0, 0, 0, 0, 0, 0, 0, 0);                                  // reset
      vin(0, 0, 0, 0, 0, 0, 0, 0);
      vin(1, 1, 0, 'h100, 0, 0, 0, 0);  es('h100, 4'h0, 1);         // m0 read, zero latency
      idle_vec();
      idle_vec();
      vin(1, 0, 0, 0, 0, 0, 1, 'hDEADBEEF);  er(0, 'hDEADBEEF, 0);
      vin(1, 0, 1, 0, 'h200, 'hF, 0, 0);  es('h200, 4'hF, 0);       // m1 write
      vin(1, 0, 0, 0, 0, 0, 1, 'h11111111);  er(1, 'h11111111, 0);
      vin(1, 1, 1, 'h104, 'h204, 0, 0, 0);  es('h104, 4'h0, 1);     // tie, m0 wins
      idle_vec();
      vin(1, 0, 0, 0, 0, 0, 1, 'h22222222);  er(0, 'h22222222, 0);
      idle_vec();  es('h204, 4'h0, 0);                              // loser from buffer
      idle_vec();
      vin(1, 0, 0, 0, 0, 0, 1, 'h33333333);  er(1, 'h33333333, 0);
      vin(1, 1, 0, 'h108, 0, 0, 0, 0);  es('h108, 4'h0, 1);
      vin(1, 0, 1, 0, 'h208, 'h5, 1, 'h44444444);  er(0, 'h44444444, 0); // req with s_ready
      idle_vec();  es('h208, 4'h5, 0);
      vin(1, 0, 0, 0, 0, 0, 1, 'h55555555);  er(1, 'h55555555, 0);
      vin(1, 0, 0, 0, 0, 0, 1, 'h66666666);                         // s_ready in IDLE ignored
      vin(1, 1, 0, 'h10C, 0, 0, 0, 0);  es('h10C, 4'h0, 1);
      vin(1, 0, 1, 0, 'h20C, 0, 0, 0);                              // buffered
      vin(1, 0, 1, 0, 'h210, 'hF, 0, 0);                            // lost -> overflow
      cur_of = 1'b1;
      vin(1, 0, 0, 0, 0, 0, 1, 'h77777777);  er(0, 'h77777777, 0);
      idle_vec();  es('h20C, 4'h0, 0);                              // only the first one
      vin(1, 0, 0, 0, 0, 0, 1, 'h88888888);  er(1, 'h88888888, 0);
      idle_vec();
      vin(0, 0, 0, 0, 0, 0, 0, 0);                                  // reset clears overflow
      cur_of = 1'b0;
      idle_vec();
      vin(1, 0, 1, 0, 'h300, 'h3, 0, 0);  es('h300, 4'h3, 0);       // hung m1 write
      for (int k = 0; k < 7; k++) idle_vec();
      vin(1, 0, 0, 0, 0, 0, 0, 'h12345678);  er(1, 32'h0, 1);       // watchdog at +8
      vin(1, 0, 0, 0, 0, 0, 1, 'h99999999);                         // late s_ready ignored
      vin(1, 1, 0, 'h110, 0, 0, 0, 0);  es('h110, 4'h0, 1);
      vin(1, 0, 0, 0, 0, 0, 1, 'hAAAAAAAA);  er(0, 'hAAAAAAAA, 0);

      // ---- apply the table ----
      for (int i = 0; i < nv; i++) begin
         next_cycle();
         rst      = vecs[i].rst;
         m0_valid = vecs[i].v0;
         m0_addr  = vecs[i].a0;
         m1_valid = vecs[i].v1;
         m1_addr  = vecs[i].a1;
         m1_wstrb = vecs[i].ws1;
         s_ready  = vecs[i].srdy;
         s_rdata  = vecs[i].srd;
         @(negedge clk);
         check($sformatf("v%0d s_valid", i), s_valid, vecs[i].sv);
         check($sformatf("v%0d s_addr", i), s_addr, vecs[i].saddr);
         check($sformatf("v%0d s_wstrb", i), s_wstrb, vecs[i].sws);
         check($sformatf("v%0d s_instr", i), s_instr, vecs[i].sinstr);
         check($sformatf("v%0d s_wdata", i), s_wdata,
               vecs[i].sv ? (vecs[i].sinstr ? WD0 : WD1) : 32'd0);
         check($sformatf("v%0d m0_ready", i), m0_ready, vecs[i].r0);
         check($sformatf("v%0d m0_rdata", i), m0_rdata, vecs[i].d0);
         check($sformatf("v%0d m1_ready", i), m1_ready, vecs[i].r1);
         check($sformatf("v%0d m1_rdata", i), m1_rdata, vecs[i].d1);
         check($sformatf("v%0d timeout_err", i), timeout_err, vecs[i].to);
         check($sformatf("v%0d overflow_err", i), overflow_err, vecs[i].of);
      end

      // ---- 20 transactions, both masters re-requesting on completion ----
      next_cycle();
      clear_inputs();
      rst = 1'b0;
      next_cycle();
      rst         = 1'b1;
      want0       = 1'b1;
      want1       = 1'b1;
      req_cnt     = 2;
      dones       = 0;
      exp_grant   = 1'b0;
      slv_pending = 1'b0;
      slv_k       = 0;
      slv_lat     = 1;
      for (int cyc = 0; cyc < 400 && dones < 20; cyc++) begin
         if (cyc > 0) next_cycle();
         m0_valid = want0;
         m0_addr  = 32'h400;
         m1_valid = want1;
         m1_addr  = 32'h600;
         m1_wstrb = 4'd0;
         want0    = 1'b0;
         want1    = 1'b0;
         s_ready  = 1'b0;
         s_rdata  = 32'd0;
         if (slv_pending) begin
            slv_k++;
            if (slv_k == slv_lat) begin
               s_ready     = 1'b1;
               s_rdata     = $urandom;
               exp_q.push_back(s_rdata);
               slv_pending = 1'b0;
            end
         end
         @(negedge clk);
         if (s_valid) begin
            check("alt grant", s_addr, exp_grant ? 32'h600 : 32'h400);
            obs_m       = (s_addr == 32'h600);
            own_q.push_back(obs_m);
            exp_grant   = ~exp_grant;
            slv_pending = 1'b1;
            slv_k       = 0;
            slv_lat     = $urandom_range(1, 3);
         end
         if (s_ready || m0_ready || m1_ready) begin
            dones++;
            if (exp_q.size() == 0 || own_q.size() == 0) begin
               check("alt spurious ready", 32'd1, 32'd0);
            end else begin
               exp_d = exp_q.pop_front();
               exp_m = own_q.pop_front();
               check("alt m0_ready", m0_ready, exp_m == 1'b0);
               check("alt m1_ready", m1_ready, exp_m == 1'b1);
               check("alt rdata", exp_m ? m1_rdata : m0_rdata, exp_d);
            end
            if (m0_ready && req_cnt < 20) begin
               want0 = 1'b1;
               req_cnt++;
            end
            if (m1_ready && req_cnt < 20) begin
               want1 = 1'b1;
               req_cnt++;
            end
         end
      end
      check("alt completions", dones, 32'd20);
      check("alt overflow_err", overflow_err, 1'b0);

      // ---- reset while BUSY with m0 buffered ----
      next_cycle();
      clear_inputs();
      m1_valid = 1'b1;
      m1_addr  = 32'h700;
      @(negedge clk);
      check("rst m1 issue", s_addr, 32'h700);
      next_cycle();
      clear_inputs();
      m0_valid = 1'b1;
      m0_addr  = 32'h500;
      @(negedge clk);
      check("rst m0 held", s_valid, 1'b0);
      next_cycle();
      clear_inputs();
      rst = 1'b0;
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      check("rst s_valid", s_valid, 1'b0);
      check("rst s_addr", s_addr, 32'd0);
      check("rst m0_ready", m0_ready, 1'b0);
      check("rst m1_ready", m1_ready, 1'b0);
      check("rst timeout_err", timeout_err, 1'b0);
      check("rst overflow_err", overflow_err, 1'b0);
      next_cycle();
      s_ready = 1'b1;
      s_rdata = 32'h0000_0BAD;
      @(negedge clk);
      check("rst stale m0_ready", m0_ready, 1'b0);
      check("rst stale m1_ready", m1_ready, 1'b0);
      check("rst stale m1_rdata", m1_rdata, 32'd0);
      next_cycle();
      clear_inputs();
      m0_valid = 1'b1;
      m0_addr  = 32'h508;
      @(negedge clk);
      check("rst next s_valid", s_valid, 1'b1);
      check("rst next s_addr", s_addr, 32'h508);
      next_cycle();
      clear_inputs();
      s_ready = 1'b1;
      s_rdata = 32'hC0FF_EE00;
      @(negedge clk);
      check("rst next m0_ready", m0_ready, 1'b1);
      check("rst next m0_rdata", m0_rdata, 32'hC0FF_EE00);
      next_cycle();
      clear_inputs();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
